// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter feeding the postfix evaluator.
// Optional build macro INFIX_ERR_DETECT_EN enables malformed-expression detection on ERR.
module infix_to_postfix #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] IN,
  input  logic       IN_VALID,
  input  logic       OP_MODE,
  output logic [3:0] OUT,
  output logic       OUT_OP_MODE,
  output logic       OUT_VALID,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONVERT, S_FLUSH, S_EMIT} state_t;

  localparam logic [3:0]  C_ADD   = 4'b0001;
  localparam logic [3:0]  C_SUB   = 4'b0010;
  localparam logic [3:0]  C_MUL   = 4'b0100;
  localparam logic [3:0]  C_LP    = 4'b1000;
  localparam logic [3:0]  C_RP    = 4'b1001;
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic [4:0]  in_buf_q  [DEPTH];
  logic [4:0]  in_buf_d  [DEPTH];
  logic [4:0]  out_buf_q [DEPTH];
  logic [4:0]  out_buf_d [DEPTH];
  logic [3:0]  stack_q   [DEPTH];
  logic [3:0]  stack_d   [DEPTH];
  logic [AW:0] in_cnt_q, in_cnt_d, rd_q, rd_d, out_cnt_q, out_cnt_d;
  logic [AW:0] sp_q, sp_d, emit_q, emit_d, sp_m1, emit_nx;
  logic [4:0]  tok, emit_tok;
  logic [3:0]  top, cur_norm;
  logic        empty, top_is_op, top_prec, cur_prec;
`ifdef INFIX_ERR_DETECT_EN
  logic        err_q, err_d, expect_q, expect_d, last_op_q, last_op_d;
`endif

  always_comb begin
    tok       = in_buf_q[rd_q[AW-1:0]];
    sp_m1     = sp_q - ONE_C;
    top       = stack_q[sp_m1[AW-1:0]];
    empty     = (sp_q == '0);
    top_is_op = !empty && (top != C_LP);
    top_prec  = (top == C_MUL);
    // Undefined operator codes degrade to add when detection is not built in.
    cur_norm  = ((tok[3:0] == C_SUB) || (tok[3:0] == C_MUL)) ? tok[3:0] : C_ADD;
    cur_prec  = (cur_norm == C_MUL);
    emit_nx   = emit_q + ONE_C;

    state_d   = state_q;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    stack_d   = stack_q;
    in_cnt_d  = in_cnt_q;
    rd_d      = rd_q;
    out_cnt_d = out_cnt_q;
    sp_d      = sp_q;
    emit_d    = emit_q;
`ifdef INFIX_ERR_DETECT_EN
    err_d     = err_q;
    expect_d  = expect_q;
    last_op_d = last_op_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          in_buf_d[0] = {OP_MODE, IN};
          in_cnt_d    = ONE_C;
          rd_d        = '0;
          out_cnt_d   = '0;
          sp_d        = '0;
          emit_d      = '0;
          state_d     = S_LOAD;
`ifdef INFIX_ERR_DETECT_EN
          err_d       = 1'b0;
          expect_d    = 1'b1;
          last_op_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (!IN_VALID) begin
          state_d = S_CONVERT;
        end else if (in_cnt_q < DEPTH_C) begin
          in_buf_d[in_cnt_q[AW-1:0]] = {OP_MODE, IN};
          in_cnt_d = in_cnt_q + ONE_C;
        end else begin
`ifdef INFIX_ERR_DETECT_EN
          err_d = 1'b1;
`endif
        end
      end
      S_CONVERT: begin
        if (rd_q == in_cnt_q) begin
          state_d = S_FLUSH;
`ifdef INFIX_ERR_DETECT_EN
          if (last_op_q) err_d = 1'b1;
`endif
        end else if (!tok[4]) begin
          out_buf_d[out_cnt_q[AW-1:0]] = tok;
          out_cnt_d = out_cnt_q + ONE_C;
          rd_d      = rd_q + ONE_C;
`ifdef INFIX_ERR_DETECT_EN
          if (!expect_q) err_d = 1'b1;
          expect_d  = 1'b0;
          last_op_d = 1'b0;
`endif
        end else if (tok[3:0] == C_LP) begin
          stack_d[sp_q[AW-1:0]] = C_LP;
          sp_d = sp_q + ONE_C;
          rd_d = rd_q + ONE_C;
`ifdef INFIX_ERR_DETECT_EN
          expect_d = 1'b1;
`endif
        end else if ((tok[3:0] == C_RP) && top_is_op) begin
          out_buf_d[out_cnt_q[AW-1:0]] = {1'b1, top};
          out_cnt_d = out_cnt_q + ONE_C;
          sp_d      = sp_m1;
        end else if (tok[3:0] == C_RP) begin
          // Top is '(' (drop the pair) or stack empty (drop the stray ')').
          if (!empty) sp_d = sp_m1;
          rd_d = rd_q + ONE_C;
`ifdef INFIX_ERR_DETECT_EN
          if (empty || last_op_q) err_d = 1'b1;
          expect_d = 1'b0;
`endif
        end else if (top_is_op && (top_prec || !cur_prec)) begin
          out_buf_d[out_cnt_q[AW-1:0]] = {1'b1, top};
          out_cnt_d = out_cnt_q + ONE_C;
          sp_d      = sp_m1;
        end else begin
          stack_d[sp_q[AW-1:0]] = cur_norm;
          sp_d = sp_q + ONE_C;
          rd_d = rd_q + ONE_C;
`ifdef INFIX_ERR_DETECT_EN
          if (expect_q || ((tok[3:0] != C_ADD) && (tok[3:0] != C_SUB) && (tok[3:0] != C_MUL)))
            err_d = 1'b1;
          expect_d  = 1'b1;
          last_op_d = 1'b1;
`endif
        end
      end
      S_FLUSH: begin
        if (empty) begin
          emit_d  = '0;
          state_d = (out_cnt_q == '0) ? S_IDLE : S_EMIT;
`ifdef INFIX_ERR_DETECT_EN
          if (err_q) state_d = S_IDLE;
`endif
        end else begin
          sp_d = sp_m1;
          if (top != C_LP) begin
            out_buf_d[out_cnt_q[AW-1:0]] = {1'b1, top};
            out_cnt_d = out_cnt_q + ONE_C;
          end else begin
`ifdef INFIX_ERR_DETECT_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      S_EMIT: begin
        emit_d = emit_nx;
        if (emit_nx == out_cnt_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      rd_q      <= '0;
      out_cnt_q <= '0;
      sp_q      <= '0;
      emit_q    <= '0;
`ifdef INFIX_ERR_DETECT_EN
      err_q     <= 1'b0;
      expect_q  <= 1'b1;
      last_op_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      rd_q      <= rd_d;
      out_cnt_q <= out_cnt_d;
      sp_q      <= sp_d;
      emit_q    <= emit_d;
`ifdef INFIX_ERR_DETECT_EN
      err_q     <= err_d;
      expect_q  <= expect_d;
      last_op_q <= last_op_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    in_buf_q  <= in_buf_d;
    out_buf_q <= out_buf_d;
    stack_q   <= stack_d;
  end

  always_comb begin
    emit_tok    = out_buf_q[emit_q[AW-1:0]];
    OUT_VALID   = (state_q == S_EMIT);
    OUT         = OUT_VALID ? emit_tok[3:0] : '0;
    OUT_OP_MODE = OUT_VALID && emit_tok[4];
    BUSY        = (state_q == S_CONVERT) || (state_q == S_FLUSH) || (state_q == S_EMIT);
  end

`ifdef INFIX_ERR_DETECT_EN
  assign ERR = (state_q == S_FLUSH) && empty && err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_infix_to_postfix.sv
// Directed bench for infix_to_postfix: postfix order, contiguity, reset abort, error handling.
module tb_infix_to_postfix;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] IN;
  logic       IN_VALID;
  logic       OP_MODE;
  logic [3:0] OUT;
  logic       OUT_OP_MODE;
  logic       OUT_VALID;
  logic       BUSY;
  logic       ERR;

  localparam logic [4:0] T_ADD = 5'h11;
  localparam logic [4:0] T_SUB = 5'h12;
  localparam logic [4:0] T_MUL = 5'h14;
  localparam logic [4:0] T_LP  = 5'h18;
  localparam logic [4:0] T_RP  = 5'h19;

  int total = 0;
  int bad   = 0;
  logic [4:0] tq[$];
  logic [4:0] eq[$];

  infix_to_postfix #(.DEPTH(32), .AW(5)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE),
    .OUT(OUT), .OUT_OP_MODE(OUT_OP_MODE), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send();
    foreach (tq[k]) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      {OP_MODE, IN} = tq[k];
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    OP_MODE  = 1'b0;
    IN       = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!OUT_VALID && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_start"}, 32'(OUT_VALID), 32'd1);
  endtask

  task automatic expect_stream(input string tag);
    send();
    wait_valid(tag);
    foreach (eq[k]) begin
      check($sformatf("%s_tok%0d", tag, k), 32'({OUT_OP_MODE, OUT}), 32'(eq[k]));
      check($sformatf("%s_vld%0d", tag, k), 32'(OUT_VALID), 32'd1);
      @(negedge CLK);
    end
    check({tag, "_end_vld"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_end_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_end_out"}, 32'({OUT_OP_MODE, OUT}), 32'd0);
  endtask

  task automatic expect_silent(input string tag, input int exp_err);
    int errs;
    int vlds;
    send();
    errs = 0;
    vlds = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge CLK);
      if (ERR) errs++;
      if (OUT_VALID) vlds++;
    end
    check({tag, "_err"}, 32'(errs), 32'(exp_err));
    check({tag, "_vld"}, 32'(vlds), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    OP_MODE  = 1'b0;
    IN       = '0;
    repeat (2) @(negedge CLK);
    check("rst_vld", 32'(OUT_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_out", 32'({OUT_OP_MODE, OUT}), 32'd0);
    RESET = 1'b1;

    tq = '{5'd3, T_ADD, 5'd4, T_MUL, 5'd2};
    eq = '{5'd3, 5'd4, 5'd2, T_MUL, T_ADD};
    expect_stream("prec");

    tq = '{T_LP, 5'd1, T_ADD, 5'd2, T_RP, T_MUL, 5'd3};
    eq = '{5'd1, 5'd2, T_ADD, 5'd3, T_MUL};
    expect_stream("paren");

    tq = '{5'd5, T_SUB, 5'd3, T_SUB, 5'd1};
    eq = '{5'd5, 5'd3, T_SUB, 5'd1, T_SUB};
    expect_stream("leftassoc");

    tq = '{5'd2, T_MUL, 5'd3, T_ADD, 5'd4};
    eq = '{5'd2, 5'd3, T_MUL, 5'd4, T_ADD};
    expect_stream("mulfirst");

    tq = '{5'd9, T_MUL, T_LP, 5'd8, T_SUB, 5'd6, T_RP};
    eq = '{5'd9, 5'd8, 5'd6, T_SUB, T_MUL};
    expect_stream("nested");

    tq = '{5'd7};
    eq = '{5'd7};
    expect_stream("single");

    tq = '{5'd15, T_ADD, 5'd0};
    eq = '{5'd15, 5'd0, T_ADD};
    expect_stream("extremes");

    // Reset during the second EMIT cycle, then a fresh expression.
    tq = '{5'd3, T_ADD, 5'd4, T_MUL, 5'd2};
    send();
    wait_valid("abort");
    check("abort_tok0", 32'({OUT_OP_MODE, OUT}), 32'd3);
    @(negedge CLK);
    check("abort_tok1", 32'({OUT_OP_MODE, OUT}), 32'd4);
    #1 RESET = 1'b0;
    #1;
    check("abort_vld", 32'(OUT_VALID), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_out", 32'({OUT_OP_MODE, OUT}), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    tq = '{5'd2, T_MUL, 5'd2};
    eq = '{5'd2, 5'd2, T_MUL};
    expect_stream("after_rst");

    // 33 tokens: operands 0..16 joined by '+'; the 33rd is beyond DEPTH.
    tq.delete();
    for (int k = 0; k < 33; k++) tq.push_back((k % 2 == 0) ? {1'b0, 4'(k / 2)} : T_ADD);

`ifdef INFIX_ERR_DETECT_EN
    expect_silent("overflow", 1);

    tq = '{T_LP, 5'd1, T_ADD, 5'd2};
    expect_silent("open_lp", 1);

    tq = '{5'd1, T_RP, T_ADD, 5'd2};
    expect_silent("stray_rp", 1);

    tq = '{5'd1, 5'd2, T_ADD, 5'd3};
    expect_silent("adj_operand", 1);

    tq = '{5'd1, T_ADD, T_MUL, 5'd3};
    expect_silent("adj_operator", 1);

    tq = '{T_SUB, 5'd4};
    expect_silent("lead_op", 1);

    tq = '{5'd1, 5'h13, 5'd2};
    expect_silent("undef_op", 1);
`else
    eq.delete();
    eq.push_back(5'd0);
    for (int k = 1; k < 16; k++) begin
      eq.push_back({1'b0, 4'(k)});
      eq.push_back(T_ADD);
    end
    eq.push_back(T_ADD);
    expect_stream("overflow");

    tq = '{T_LP, 5'd1, T_ADD, 5'd2};
    eq = '{5'd1, 5'd2, T_ADD};
    expect_stream("open_lp");

    tq = '{5'd1, T_RP, T_ADD, 5'd2};
    eq = '{5'd1, 5'd2, T_ADD};
    expect_stream("stray_rp");

    tq = '{5'd1, 5'h13, 5'd2};
    eq = '{5'd1, 5'd2, T_ADD};
    expect_stream("undef_op");

    tq = '{T_LP, T_RP};
    expect_silent("parens_only", 0);
`endif

    tq = '{5'd6, T_SUB, 5'd1};
    eq = '{5'd6, 5'd1, T_SUB};
    expect_stream("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
